// File: rtl/mdu_pkg.sv
// Shared encodings, default latencies and FSM state type for the HI/LO multiply/divide unit.
package mdu_pkg;

  typedef enum logic [2:0] {
    OpMult  = 3'd0,
    OpMultu = 3'd1,
    OpDiv   = 3'd2,
    OpDivu  = 3'd3,
    OpMthi  = 3'd4,
    OpMtlo  = 3'd5
  } md_op_e;

  typedef enum logic {
    StIdle,
    StRun
  } md_state_e;

  localparam int unsigned MultCyclesDef = 5;
  localparam int unsigned DivCyclesDef  = 10;
  localparam int unsigned CntWDef       = 4;

  // Multi-cycle ops occupy the lower half of the encoding space.
  function automatic logic is_long_op(input logic [2:0] op);
    return (op[2] == 1'b0);
  endfunction

  function automatic logic is_div_op(input logic [2:0] op);
    return (op == OpDiv) || (op == OpDivu);
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational multiply/divide datapath producing the 64-bit {hi,lo} result for one MD op.
module mdu_arith
  import mdu_pkg::*;
(
  input  logic [2:0]  op_i,
  input  logic [31:0] rs_i,
  input  logic [31:0] rt_i,
  output logic [63:0] res_o,
  output logic        div_zero_o
);

  logic [63:0] smul;
  logic [63:0] umul;
  logic [31:0] divisor;
  logic [31:0] squot, srem;
  logic [31:0] uquot, urem;
  logic        sdiv_ovf;

  assign smul = $signed({{32{rs_i[31]}}, rs_i}) * $signed({{32{rt_i[31]}}, rt_i});
  assign umul = {32'd0, rs_i} * {32'd0, rt_i};

  // A zero divisor is replaced so the dividers never see it; the result is discarded anyway.
  assign divisor    = (rt_i == 32'd0) ? 32'd1 : rt_i;
  assign div_zero_o = is_div_op(op_i) && (rt_i == 32'd0);
  assign sdiv_ovf   = (rs_i == 32'h8000_0000) && (rt_i == 32'hFFFF_FFFF);

  always_comb begin
    squot = 32'd0;
    srem  = 32'd0;
    if (sdiv_ovf) begin
      squot = 32'h8000_0000;
      srem  = 32'd0;
    end else begin
      squot = $signed(rs_i) / $signed(divisor);
      srem  = $signed(rs_i) % $signed(divisor);
    end
  end

  assign uquot = rs_i / divisor;
  assign urem  = rs_i % divisor;

  always_comb begin
    res_o = 64'd0;
    case (op_i)
      OpMult:  res_o = smul;
      OpMultu: res_o = umul;
      OpDiv:   res_o = {srem, squot};
      OpDivu:  res_o = {urem, uquot};
      default: res_o = 64'd0;
    endcase
  end

endmodule

// File: rtl/mdu_ctrl.sv
// Multi-cycle HI/LO controller: sequences MD ops with a down-counter, commits HI/LO, requests stalls.
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MultCyclesDef,
  parameter int unsigned DIV_CYCLES  = DivCyclesDef,
  parameter int unsigned CNT_W       = CntWDef
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic [2:0]  op_i,
  input  logic [31:0] rs_val_i,
  input  logic [31:0] rt_val_i,
  input  logic        d_md_use_i,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        stall_o,
  output logic        err_o
);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [63:0]      pend_q, pend_d;
  logic             dz_q, dz_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic [63:0]      arith_res;
  logic             arith_dz;
  logic [CNT_W-1:0] op_lat;

  mdu_arith u_arith (
    .op_i       (op_i),
    .rs_i       (rs_val_i),
    .rt_i       (rt_val_i),
    .res_o      (arith_res),
    .div_zero_o (arith_dz)
  );

  assign op_lat = is_div_op(op_i) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    dz_d    = dz_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = err_q;
    case (state_q)
      StIdle: begin
        if (start_i) begin
          if (is_long_op(op_i)) begin
            pend_d  = arith_res;
            dz_d    = arith_dz;
            cnt_d   = op_lat;
            busy_d  = 1'b1;
            state_d = StRun;
          end else if (op_i == OpMthi) begin
            hi_d = rs_val_i;
          end else if (op_i == OpMtlo) begin
            lo_d = rs_val_i;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StRun: begin
        // Issue while busy is a pipeline protocol bug; the request is dropped.
        if (start_i) begin
          err_d = 1'b1;
        end
        if (cnt_q == CNT_W'(1)) begin
          if (!dz_q) begin
            hi_d = pend_q[63:32];
            lo_d = pend_q[31:0];
          end
          cnt_d   = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      pend_q  <= '0;
      dz_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      dz_q    <= dz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign hi_o    = hi_q;
  assign lo_o    = lo_q;
  assign busy_o  = busy_q;
  assign done_o  = done_q;
  assign err_o   = err_q;
  assign stall_o = d_md_use_i & (busy_q | (start_i & is_long_op(op_i)));

endmodule

// File: doc/mdu_ctrl.md
# mdu_ctrl

Multi-cycle controller for the HI/LO multiply/divide unit in the E stage of the five-stage pipeline. It accepts one MD operation per issue, sequences it over a fixed latency with a down-counter, commits results to the architectural HI/LO registers, and drives the MD-class stall request that the pipeline hazard logic ORs into its existing stall term (PC write disable, IF/ID hold, ID/EX clear).

## Interface
- MULT_CYCLES, 5, busy cycles for mult/multu (≥1)
- DIV_CYCLES, 10, busy cycles for div/divu (≥1)
- CNT_W, 4, counter width; must hold max(MULT_CYCLES, DIV_CYCLES)
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start_i  in  1  E-stage instruction is a valid MD write op this cycle
- op_i  in  3  0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo; others reserved
- rs_val_i  in  32  forwarded rs operand (E stage)
- rt_val_i  in  32  forwarded rt operand (E stage)
- d_md_use_i  in  1  D-stage instruction is MD-class (mult/multu/div/divu/mthi/mtlo/mfhi/mflo)
- hi_o  out  32  architectural HI, read by mfhi
- lo_o  out  32  architectural LO, read by mflo
- busy_o  out  1  multi-cycle op in flight
- done_o  out  1  one-cycle pulse on the cycle after HI/LO commit
- stall_o  out  1  MD stall request to hazard logic
- err_o  out  1  sticky protocol-violation flag

## Operation
- States: IDLE, RUN. Reset → IDLE; hi_o=0, lo_o=0, busy_o=0, done_o=0, err_o=0, counter=0, pending regs=0.
- IDLE, start_i=1, op mult/multu/div/divu: latch computed {hi,lo} into pending regs, load counter with MULT_CYCLES or DIV_CYCLES, → RUN.
- IDLE, start_i=1, op mthi/mtlo: write rs_val_i into HI/LO at that edge; stay IDLE; no done pulse.
- RUN: counter decrements each cycle; on the edge where counter==1, commit pending to HI/LO, → IDLE, done_o=1 for the following cycle.
- mult: signed 32×32→64, HI=[63:32], LO=[31:0]. multu: unsigned.
- div: signed, LO=quotient truncated toward zero, HI=remainder with sign of dividend. divu: unsigned.
- Divide by zero (rt_val_i==0): op runs full DIV_CYCLES, HI/LO unchanged at commit.
- Signed 0x80000000 / -1: LO=0x80000000, HI=0.
- start_i=1 while RUN: ignored (no state change), err_o set, holds until reset.
- Reserved op_i with start_i=1: ignored, err_o set.
- stall_o = d_md_use_i & (busy_o | (start_i & op_i∈{0..3})). mthi/mtlo never stall.
- Reset asserted mid-RUN: immediate return to reset values; pending result discarded.

## Timing
- Op sampled at edge k: busy_o high cycles k+1 .. k+N (N = MULT_CYCLES/DIV_CYCLES); HI/LO updated at edge k+N; busy_o low and done_o high in cycle k+N+1.
- mfhi/mflo in D while busy: stalled until busy_o falls; reads new HI/LO in E the cycle after.
- Back-to-back: new op may issue the cycle busy_o falls (same cycle as done_o).
- mthi/mtlo: HI/LO visible on hi_o/lo_o the cycle after issue.
- hi_o/lo_o, busy_o, done_o, err_o are registered; stall_o is combinational.

## Structure
- mdu_pkg: op_i encodings, default latency constants, state enum.
- Sub-module mdu_arith: purely combinational; op, rs, rt → 64-bit {hi,lo} result plus div-by-zero flag. Controller instantiates it once.

## Test plan
- mult rs=0xFFFFFFFF, rt=2 at edge k → busy_o k+1..k+5; HI=0xFFFFFFFF, LO=0xFFFFFFFE after k+5; done_o in k+6.
- multu same operands → HI=0x00000001, LO=0xFFFFFFFE.
- div rs=-7, rt=2 → after 10 busy cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF; d_md_use_i=1 throughout → stall_o=1 for cycles k..k+10, 0 in k+11.
- divu rt=0 with HI=0x11, LO=0x22 preloaded via mthi/mtlo → runs 10 cycles, HI=0x11, LO=0x22 unchanged; err_o=0.
- start_i mult during RUN → ignored, original result committed on schedule, err_o=1 sticky.
- rst_n pulled low at cycle 3 of div → busy_o=0, HI=LO=0 immediately; done_o never pulses.
